// File: rtl/sa_ram_rd_ctrl_256x128_if.sv
// ---------------------------------------------------------------------------
// sa_ram_rd_ctrl_256x128_if
//
// Groups the request handshake, the RAM read port and the output beat
// stream of the burst read controller into one bundle.
//
//   req_valid / req_ready      burst request handshake
//   req_addr  [7:0]            first RAM word of the burst
//   req_len   [7:0]            burst length minus one
//   ram_re / ram_ra [7:0]      RAM read enable / read address
//   ram_dout  [127:0]          RAM read data (one cycle after ram_re)
//   rd_pvld / rd_prdy          output beat handshake
//   rd_pd     [127:0]          output beat data
//   rd_last                    final beat of the burst
//   done                       pulse when the final beat handshakes
//
// Modports:
//   master - the controller (drives requests' ready, RAM port, beat stream)
//   slave  - the environment (requester, RAM model, downstream consumer)
// ---------------------------------------------------------------------------
interface sa_ram_rd_ctrl_256x128_if;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_addr;
    logic [7:0]   req_len;
    logic         ram_re;
    logic [7:0]   ram_ra;
    logic [127:0] ram_dout;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [127:0] rd_pd;
    logic         rd_last;
    logic         done;

    modport master (
        input  req_valid, req_addr, req_len, ram_dout, rd_prdy,
        output req_ready, ram_re, ram_ra, rd_pvld, rd_pd, rd_last, done
    );

    modport slave (
        output req_valid, req_addr, req_len, ram_dout, rd_prdy,
        input  req_ready, ram_re, ram_ra, rd_pvld, rd_pd, rd_last, done
    );
endinterface

// File: rtl/sa_ram_rd_ctrl_256x128.sv
// ---------------------------------------------------------------------------
// sa_ram_rd_ctrl_256x128
//
// Burst read controller for a 256 x 128-bit RAM. Accepts a (start address,
// length-1) request, issues consecutive RAM reads with wrapping addresses,
// and streams the returned words through a 2-entry output FIFO with a
// valid/ready handshake. A read is only issued when the FIFO is guaranteed
// to have room for its data, so the FIFO can never overflow regardless of
// downstream back-pressure.
//
// Ports:
//   nvdla_core_clk   clock, rising edge
//   nvdla_core_rstn  asynchronous active-low reset
//   bus              sa_ram_rd_ctrl_256x128_if.master (request, RAM read
//                    port and output beat stream)
// ---------------------------------------------------------------------------
module sa_ram_rd_ctrl_256x128 (
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rstn,
    sa_ram_rd_ctrl_256x128_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_nextState;

    logic [7:0]   r_curAddr;
    logic [7:0]   r_remaining;
    logic         r_inflight;
    logic         r_inflightLast;

    logic [127:0] r_fifoData [2];
    logic [1:0]   r_fifoLast;
    logic         r_rdPtr;
    logic         r_wrPtr;
    logic [1:0]   r_occ;

    logic         w_accept;
    logic         w_pop;
    logic         w_push;
    logic [2:0]   w_occProjected;
    logic         w_credit;
    logic         w_issue;
    logic         w_issueLast;
    logic         w_done;

    assign w_accept    = bus.req_valid && (r_state == IDLE);
    assign w_pop       = (r_occ != 2'd0) && bus.rd_prdy;
    assign w_push      = r_inflight;

    // Occupancy the FIFO will have next cycle before this cycle's read lands.
    // A new read is safe only if that leaves a free slot for its data.
    assign w_occProjected = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit       = (w_occProjected < 3'd2);

    assign w_issue     = (r_state == RUN) && w_credit;
    assign w_issueLast = w_issue && (r_remaining == 8'd0);

    // The last tag only exists on the final beat, so this fires only in DRAIN.
    assign w_done      = w_pop && r_fifoLast[r_rdPtr];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_nextState = RUN;
            RUN:     if (w_issueLast) w_nextState = DRAIN;
            DRAIN:   if (w_done)      w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    // Address and beat counter: loaded on acceptance, stepped per issued read.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_curAddr   <= 8'd0;
            r_remaining <= 8'd0;
        end else if (w_accept) begin
            r_curAddr   <= bus.req_addr;
            r_remaining <= bus.req_len;
        end else if (w_issue) begin
            r_curAddr <= r_curAddr + 8'd1;
            if (r_remaining != 8'd0) begin
                r_remaining <= r_remaining - 8'd1;
            end
        end
    end

    // Marks the cycle in which RAM data for last cycle's read is on ram_dout.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
        end else begin
            r_inflight     <= w_issue;
            r_inflightLast <= w_issueLast;
        end
    end

    // Two-entry output FIFO; the head entry drives the beat outputs directly.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_fifoData[0] <= '0;
            r_fifoData[1] <= '0;
            r_fifoLast    <= 2'b00;
            r_rdPtr       <= 1'b0;
            r_wrPtr       <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifoData[r_wrPtr] <= bus.ram_dout;
                r_fifoLast[r_wrPtr] <= r_inflightLast;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 2'd1;
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.ram_re    = w_issue;
    assign bus.ram_ra    = r_curAddr;
    assign bus.rd_pvld   = (r_occ != 2'd0);
    assign bus.rd_pd     = r_fifoData[r_rdPtr];
    assign bus.rd_last   = r_fifoLast[r_rdPtr];
    assign bus.done      = w_done;

endmodule

// File: tb/tb_sa_ram_rd_ctrl_256x128.sv
// ---------------------------------------------------------------------------
// tb_sa_ram_rd_ctrl_256x128
//
// Drives bursts into the read controller against a behavioural RAM and
// checks every cycle against a transaction-level reference: each accepted
// request expands into a queue of expected (data, last) beats computed from
// the RAM contents, and every handshaken beat must match the queue head.
// ---------------------------------------------------------------------------
module tb_sa_ram_rd_ctrl_256x128;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    sa_ram_rd_ctrl_256x128_if intf();

    sa_ram_rd_ctrl_256x128 dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (intf)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural RAM: registered read, output held when not reading.
    logic [127:0] mem [256];
    logic [127:0] ramDout = '0;

    always @(posedge clk) begin
        if (intf.ram_re) ramDout <= mem[intf.ram_ra];
    end
    assign intf.ram_dout = ramDout;

    // Downstream ready: always ready, or random, with an optional forced stall.
    int prdyMode  = 0;
    int stallLeft = 0;

    always @(posedge clk) begin
        #1;
        if (stallLeft > 0) begin
            intf.rd_prdy = 1'b0;
            stallLeft--;
        end else if (prdyMode == 0) begin
            intf.rd_prdy = 1'b1;
        end else begin
            intf.rd_prdy = 1'($urandom % 2);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model state.
    beat_t expQ[$];
    int    cycle = 0;
    bit    busy = 0;
    int    bAddr = 0;
    int    bLen = 0;
    int    issued = 0;
    int    acceptCycle = -10;
    int    firstReCycle = 0;
    int    firstPvldCycle = 0;
    int    firstBeatCycle = 0;
    int    lastBeatCycle = 0;
    bit    sawPvld = 0;
    bit    sawBeat = 0;
    int    beatCount = 0;
    int    doneCount = 0;
    int    acceptCount = 0;
    bit    prevStall = 0;
    logic [127:0] prevPd = '0;
    logic  prevLast = 1'b0;

    // Cycle monitor, sampled mid-cycle.
    always @(negedge clk) begin
        bit    hs;
        bit    acc;
        bit    expDone;
        beat_t b;
        if (!rstn) begin
            busy      = 0;
            prevStall = 0;
            expQ.delete();
        end else begin
            cycle++;
            acc = intf.req_valid && !busy;
            checkOutput("req_ready", intf.req_ready, !busy);

            if (prevStall) begin
                checkOutput("stall_pvld", intf.rd_pvld, 1);
                checkOutput("stall_pd", intf.rd_pd, prevPd);
                checkOutput("stall_last", intf.rd_last, prevLast);
            end

            if (busy && cycle == acceptCycle + 1) checkOutput("first_re", intf.ram_re, 1);
            if (intf.ram_re) begin
                checkOutput("re_allowed", busy && issued <= bLen, 1);
                checkOutput("ram_ra", intf.ram_ra, (bAddr + issued) % 256);
                if (issued == 0) firstReCycle = cycle;
                issued++;
            end

            if (intf.rd_pvld && busy && !sawPvld) begin
                sawPvld        = 1;
                firstPvldCycle = cycle;
                checkOutput("pvld_latency", (cycle - firstReCycle) >= 2, 1);
            end

            hs      = intf.rd_pvld && intf.rd_prdy;
            expDone = 0;
            if (hs) begin
                beatCount++;
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat", 1, 0);
                end else begin
                    b = expQ.pop_front();
                    checkOutput("beat_pd", intf.rd_pd, b.data);
                    checkOutput("beat_last", intf.rd_last, b.last);
                    expDone = b.last;
                    if (!sawBeat) firstBeatCycle = cycle;
                    sawBeat       = 1;
                    lastBeatCycle = cycle;
                end
            end
            checkOutput("done", intf.done, expDone);

            if (expDone) begin
                busy = 0;
                doneCount++;
                checkOutput("re_count", issued, bLen + 1);
                checkOutput("q_empty", expQ.size(), 0);
            end

            if (acc) begin
                busy         = 1;
                bAddr        = int'(intf.req_addr);
                bLen         = int'(intf.req_len);
                issued       = 0;
                acceptCycle  = cycle;
                firstReCycle = cycle + 1000;
                sawPvld      = 0;
                sawBeat      = 0;
                acceptCount++;
                for (int i = 0; i <= bLen; i++) begin
                    b.data = mem[(bAddr + i) % 256];
                    b.last = (i == bLen);
                    expQ.push_back(b);
                end
            end

            prevStall = intf.rd_pvld && !intf.rd_prdy;
            prevPd    = intf.rd_pd;
            prevLast  = intf.rd_last;
        end
    end

    // Presents one request for a single cycle; called at posedge+1 while idle.
    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] len);
        intf.req_addr  = addr;
        intf.req_len   = len;
        intf.req_valid = 1'b1;
        @(posedge clk);
        #1;
        intf.req_valid = 1'b0;
        intf.req_addr  = 8'($urandom);
        intf.req_len   = 8'($urandom);
    endtask

    task automatic waitForDone(input int target);
        int guard = 0;
        while (doneCount < target && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (doneCount < target) checkOutput("burst_timeout", 0, 1);
        #1;
    endtask

    task automatic waitForBeats(input int target);
        int guard = 0;
        while (beatCount < target && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (beatCount < target) checkOutput("beat_timeout", 0, 1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_req_ready", intf.req_ready, 1);
        checkOutput("rst_ram_re", intf.ram_re, 0);
        checkOutput("rst_ram_ra", intf.ram_ra, 0);
        checkOutput("rst_rd_pvld", intf.rd_pvld, 0);
        checkOutput("rst_rd_pd", intf.rd_pd, 0);
        checkOutput("rst_rd_last", intf.rd_last, 0);
        checkOutput("rst_done", intf.done, 0);
    endtask

    initial begin
        int d0;
        int a0;
        int guard;
        rstn           = 1'b0;
        intf.req_valid = 1'b0;
        intf.req_addr  = 8'd0;
        intf.req_len   = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 128'(i);

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Basic four-beat burst, then address wrap.
        applyStimulus(8'h10, 8'd3);
        waitForDone(doneCount + 1);
        checkOutput("consec_10", lastBeatCycle - firstBeatCycle, 3);

        applyStimulus(8'hFE, 8'd3);
        waitForDone(doneCount + 1);
        checkOutput("consec_fe", lastBeatCycle - firstBeatCycle, 3);

        // Single-beat burst with exact latencies.
        applyStimulus(8'h42, 8'd0);
        waitForDone(doneCount + 1);
        checkOutput("len0_re_lat", firstReCycle - acceptCycle, 1);
        checkOutput("len0_pvld_lat", firstPvldCycle - firstReCycle, 2);
        checkOutput("len0_re_count", issued, 1);

        // Eight beats under random back-pressure with a five-cycle stall.
        prdyMode = 1;
        d0 = doneCount;
        a0 = beatCount;
        applyStimulus(8'h80, 8'd7);
        waitForBeats(a0 + 2);
        stallLeft = 5;
        waitForDone(d0 + 1);
        checkOutput("stall_beats", beatCount - a0, 8);
        prdyMode = 0;

        // Request held valid across a burst: exactly one re-acceptance.
        $display("[TB] held request");
        d0 = doneCount;
        a0 = acceptCount;
        intf.req_addr  = 8'h30;
        intf.req_len   = 8'd2;
        intf.req_valid = 1'b1;
        guard = 0;
        while (acceptCount < a0 + 2 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        intf.req_valid = 1'b0;
        waitForDone(d0 + 2);
        checkOutput("hold_accepts", acceptCount - a0, 2);

        // Reset mid-burst, then a clean burst straight after release.
        $display("[TB] reset mid-burst");
        a0 = beatCount;
        applyStimulus(8'h00, 8'd7);
        waitForBeats(a0 + 3);
        #3;
        rstn = 1'b0;
        #1;
        checkResetOutputs();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        d0 = doneCount;
        a0 = beatCount;
        applyStimulus(8'h20, 8'd1);
        waitForDone(d0 + 1);
        checkOutput("post_rst_beats", beatCount - a0, 2);

        // Random bursts over random RAM contents.
        $display("[TB] random bursts");
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 10; n++) begin
            prdyMode = int'($urandom % 2);
            d0 = doneCount;
            applyStimulus(8'($urandom), 8'($urandom_range(0, 40)));
            waitForDone(d0 + 1);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sa_ram_rd_ctrl_256x128.md
SA_RAM_RD_CTRL_256X128 -- requirements
Module: sa_ram_rd_ctrl_256x128

Interface
REQ-001 Parameters: none; RAM geometry is fixed at 256 words x 128 bits.
REQ-002 nvdla_core_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 nvdla_core_rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  burst read request valid.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 req_addr  in  8  first RAM word address of burst.
REQ-007 req_len  in  8  burst length minus one (0 -> 1 beat, 255 -> 256 beats).
REQ-008 ram_re  out  1  RAM read enable (drives RAM re).
REQ-009 ram_ra  out  8  RAM read address (drives RAM ra).
REQ-010 ram_dout  in  128  RAM read data; valid the cycle after ram_re=1, held while ram_re=0.
REQ-011 rd_pvld  out  1  output beat valid.
REQ-012 rd_prdy  in  1  downstream accepts beat.
REQ-013 rd_pd  out  128  output beat data.
REQ-014 rd_last  out  1  qualifies final beat of burst (meaningful only with rd_pvld).
REQ-015 done  out  1  single-cycle pulse: final beat of burst handshaken.

Function
REQ-016 States IDLE, RUN, DRAIN; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on req_valid&req_ready latch cur_addr=req_addr, remaining=req_len; go to RUN.
REQ-018 RUN: ram_re=1 iff credit available: occ + inflight - (rd_pvld&rd_prdy) < 2 (occ = output buffer entries 0..2, inflight = read issued last cycle).
REQ-019 ram_ra SHALL equal cur_addr at all times; each issued read increments cur_addr modulo 256 (255 -> 0 wrap).
REQ-020 Each issued read decrements remaining; the read issued with remaining==0 is tagged last, and the FSM moves to DRAIN; no further ram_re until next request.
REQ-021 inflight SHALL be set in the cycle after ram_re=1 and clear otherwise; while set, ram_dout plus its last tag SHALL be pushed into the buffer at the clock edge.
REQ-022 Output buffer: 2-entry FIFO, registered; rd_pd/rd_last from head entry; rd_pvld = (occ != 0); push and pop in same cycle SHALL keep occ unchanged and preserve order.
REQ-023 rd_pd and rd_last SHALL remain stable while rd_pvld=1 and rd_prdy=0.
REQ-024 Latency: ram_re=1 in cycle N -> corresponding beat on rd_pvld no earlier than cycle N+2; first ram_re no earlier than the cycle after request acceptance.
REQ-025 Throughput: with rd_prdy held 1, one beat per cycle sustained after initial latency; buffer SHALL never overflow under any rd_prdy pattern.
REQ-026 DRAIN: when head entry with last tag handshakes, done=1 that cycle and FSM returns to IDLE next cycle; a new request may be accepted the cycle after done.
REQ-027 req_valid while not in IDLE SHALL be ignored (not latched).
REQ-028 The block SHALL never issue writes and SHALL not depend on RAM write-port activity.

Reset
REQ-029 While nvdla_core_rstn=0: state=IDLE, req_ready=1, ram_re=0, ram_ra=0, rd_pvld=0, rd_pd=0, rd_last=0, done=0, occ=0, inflight=0, remaining=0.
REQ-030 Reset asserted mid-burst SHALL abort immediately: buffered/in-flight data discarded, no done pulse, RAM contents unaffected.
REQ-031 After deassertion, first request acceptable on the first rising edge with nvdla_core_rstn=1.

Verification
REQ-032 RAM preloaded M[i]=i; req addr=0x10 len=3, rd_prdy=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, rd_last on 0x13, done pulse same cycle.
REQ-033 req addr=0xFE len=3 -> beats 0xFE,0xFF,0x00,0x01 (address wrap).
REQ-034 req len=0 addr=0x42 -> exactly one ram_re, one beat 0x42 with rd_last=1, done=1; first ram_re cycle after acceptance, rd_pvld two cycles later.
REQ-035 len=7, rd_prdy random 50% toggle incl. 5-cycle stall -> 8 beats in order, data stable during stall, occ never >2, no lost/duplicated beat.
REQ-036 Reset asserted after 3 of 8 beats -> all outputs at reset values same cycle; subsequent request addr=0x20 len=1 yields 0x20,0x21 only, no stale data.
REQ-037 req_valid held high throughout a burst -> only the first request latched until IDLE; second accepted cycle after done.
